// File: rtl/divisor_reloj_if.sv
// rtl/divisor_reloj_if.sv - divide-ratio handshake bundle for divisor_reloj
interface divisor_reloj_if #(
    parameter int ANCHO = 8
) ();
    logic             div_valido;
    logic [ANCHO-1:0] div_dato;
    logic             div_listo;
    logic             div_error;

    modport master (
        output div_valido,
        output div_dato,
        input  div_listo,
        input  div_error
    );

    modport slave (
        input  div_valido,
        input  div_dato,
        output div_listo,
        output div_error
    );
endinterface

// File: rtl/divisor_reloj.sv
// rtl/divisor_reloj.sv - programmable glitch-free clock divider with gated start/stop
// Optional falling-edge enable output pulso_bajada when DIVISOR_PULSO_EN is defined.
module divisor_reloj #(
    parameter int ANCHO       = 8,
    parameter int DIV_INICIAL = 6
) (
    input  logic                 reloj,
    input  logic                 reset_n,
    input  logic                 habilitar,
    divisor_reloj_if.slave       div,
    output logic                 reloj_div,
    output logic [1:0]           estado
`ifdef DIVISOR_PULSO_EN
    ,
    output logic                 pulso_bajada
`endif
);

    typedef enum logic [1:0] {
        PARADO     = 2'b00,
        CORRIENDO  = 2'b01,
        DETENIENDO = 2'b10
    } estado_t;

    localparam logic [ANCHO-1:0] DIV_RST = ANCHO'(DIV_INICIAL);
    localparam logic [ANCHO-1:0] UNO     = ANCHO'(1);

    estado_t          est, est_sig;
    logic [ANCHO-1:0] cnt, cnt_sig;
    logic [ANCHO-1:0] divisor, div_pend;
    logic             reloj_div_sig;
    logic             pendiente, error_r;
    logic             corriendo, fin_fase, bajada, captura, carga;

    assign corriendo = (est != PARADO);
    assign fin_fase  = corriendo && (cnt == divisor - UNO);
    assign bajada    = fin_fase && reloj_div;
    assign captura   = div.div_valido && !pendiente;
    // New ratios only land at cnt=0 boundaries: immediately when stopped, else on a 1->0 toggle.
    assign carga     = pendiente && ((est == PARADO) || bajada);

    assign div.div_listo = !pendiente;
    assign div.div_error = error_r;
    assign estado        = est;

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            est <= PARADO;
        end else begin
            est <= est_sig;
        end
    end

    always_comb begin
        est_sig       = est;
        cnt_sig       = cnt;
        reloj_div_sig = reloj_div;
        case (est)
            PARADO: begin
                cnt_sig       = '0;
                reloj_div_sig = 1'b0;
                if (habilitar) begin
                    est_sig = CORRIENDO;
                end
            end
            CORRIENDO, DETENIENDO: begin
                if (fin_fase) begin
                    cnt_sig       = '0;
                    reloj_div_sig = ~reloj_div;
                end else begin
                    cnt_sig = cnt + UNO;
                end
                // Stopping while low never lets a new high phase start; while high it runs to completion.
                if (habilitar) begin
                    est_sig = CORRIENDO;
                end else if (!reloj_div) begin
                    est_sig       = PARADO;
                    cnt_sig       = '0;
                    reloj_div_sig = 1'b0;
                end else if (bajada) begin
                    est_sig = PARADO;
                end else begin
                    est_sig = DETENIENDO;
                end
            end
            default: begin
                est_sig       = PARADO;
                cnt_sig       = '0;
                reloj_div_sig = 1'b0;
            end
        endcase
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            reloj_div <= 1'b0;
            divisor   <= DIV_RST;
            div_pend  <= '0;
            pendiente <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            cnt       <= cnt_sig;
            reloj_div <= reloj_div_sig;
            error_r   <= 1'b0;
            if (carga) begin
                pendiente <= 1'b0;
                if (div_pend == '0) begin
                    error_r <= 1'b1;
                end else begin
                    divisor <= div_pend;
                end
            end else if (captura) begin
                pendiente <= 1'b1;
                div_pend  <= div.div_dato;
            end
        end
    end

`ifdef DIVISOR_PULSO_EN
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            pulso_bajada <= 1'b0;
        end else begin
            pulso_bajada <= bajada;
        end
    end
`endif

endmodule

// File: tb/tb_divisor_reloj.sv
// tb/tb_divisor_reloj.sv - directed self-checking bench for divisor_reloj
module tb_divisor_reloj;

    logic       reloj;
    logic       reset_n;
    logic       habilitar;
    logic       reloj_div;
    logic [1:0] estado;
`ifdef DIVISOR_PULSO_EN
    logic       pulso_bajada;
`endif

    int vectores = 0;
    int errores  = 0;
    int n;

    divisor_reloj_if #(.ANCHO(8)) bus ();

    divisor_reloj #(.ANCHO(8), .DIV_INICIAL(6)) dut (
        .reloj        (reloj),
        .reset_n      (reset_n),
        .habilitar    (habilitar),
        .div          (bus.slave),
        .reloj_div    (reloj_div),
        .estado       (estado)
`ifdef DIVISOR_PULSO_EN
        ,
        .pulso_bajada (pulso_bajada)
`endif
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectores++;
        assert (obs === exp) else begin
            errores++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic medir(input logic objetivo, output int cuenta);
        cuenta = 0;
        do begin
            tick();
            cuenta++;
        end while (reloj_div !== objetivo && cuenta < 100);
    endtask

    task automatic ofrecer(input logic [7:0] valor);
        bus.div_valido = 1'b1;
        bus.div_dato   = valor;
        tick();
        bus.div_valido = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        habilitar      = 1'b0;
        bus.div_valido = 1'b0;
        bus.div_dato   = 8'd0;
        tick();
        tick();
        chk("rst_reloj_div", 32'(reloj_div), 0);
        chk("rst_estado", 32'(estado), 0);
        chk("rst_listo", 32'(bus.div_listo), 1);
        chk("rst_error", 32'(bus.div_error), 0);

        // 1: start with N=6
        reset_n = 1'b1;
        tick();
        habilitar = 1'b1;
        tick();
        chk("t1_estado", 32'(estado), 1);
        chk("t1_low_first", 32'(reloj_div), 0);
        medir(1'b1, n);
        chk("t1_first_rise", 32'(n), 6);
        medir(1'b0, n);
        chk("t1_high", 32'(n), 6);
        medir(1'b1, n);
        chk("t1_low", 32'(n), 6);

        // 2: ratio 3 offered mid high phase
        ofrecer(8'd3);
        chk("t2_listo_busy", 32'(bus.div_listo), 0);
        medir(1'b0, n);
        chk("t2_high_rest", 32'(n), 5);
        chk("t2_listo_back", 32'(bus.div_listo), 1);
        medir(1'b1, n);
        chk("t2_low3", 32'(n), 3);
        medir(1'b0, n);
        chk("t2_high3", 32'(n), 3);

        // 3: back to N=6, then stop at cnt=2 of a high phase
        ofrecer(8'd6);
        medir(1'b1, n);
        chk("t3_low3_rest", 32'(n), 2);
        medir(1'b0, n);
        chk("t3_high3", 32'(n), 3);
        medir(1'b1, n);
        chk("t3_low6", 32'(n), 6);
        tick();
        tick();
        habilitar = 1'b0;
        tick();
        chk("t3_estado_det", 32'(estado), 2);
        chk("t3_still_high", 32'(reloj_div), 1);
        medir(1'b0, n);
        chk("t3_fall_delay", 32'(n + 1), 4);
        chk("t3_estado_par", 32'(estado), 0);
        chk("t3_cnt_zero", 32'(dut.cnt), 0);
        tick();
        chk("t3_hold_low", 32'(reloj_div), 0);

        // 4: zero ratio is rejected, then N=1
        ofrecer(8'd0);
        chk("t4_listo_busy", 32'(bus.div_listo), 0);
        chk("t4_no_err_yet", 32'(bus.div_error), 0);
        tick();
        chk("t4_err_pulse", 32'(bus.div_error), 1);
        chk("t4_listo_back", 32'(bus.div_listo), 1);
        tick();
        chk("t4_err_gone", 32'(bus.div_error), 0);
        habilitar = 1'b1;
        tick();
        medir(1'b1, n);
        chk("t4_first_rise", 32'(n), 6);
        medir(1'b0, n);
        chk("t4_high6", 32'(n), 6);
        medir(1'b1, n);
        chk("t4_low6", 32'(n), 6);
        ofrecer(8'd1);
        medir(1'b0, n);
        chk("t4_high_rest", 32'(n), 5);
        tick();
        chk("t4_div2_a", 32'(reloj_div), 1);
        tick();
        chk("t4_div2_b", 32'(reloj_div), 0);
        tick();
        chk("t4_div2_c", 32'(reloj_div), 1);

        // 5: async reset with a pending ratio during a high phase
        ofrecer(8'd5);
        tick();
        chk("t5_pre_high", 32'(reloj_div), 1);
        chk("t5_pre_pend", 32'(bus.div_listo), 0);
        reset_n   = 1'b0;
        habilitar = 1'b0;
        #1;
        chk("t5_async_div", 32'(reloj_div), 0);
        chk("t5_async_listo", 32'(bus.div_listo), 1);
        chk("t5_async_estado", 32'(estado), 0);
        tick();
        reset_n   = 1'b1;
        habilitar = 1'b1;
        tick();
        medir(1'b1, n);
        chk("t5_div_inicial", 32'(n), 6);

`ifdef DIVISOR_PULSO_EN
        // 6: falling-edge pulse with N=2
        ofrecer(8'd2);
        medir(1'b0, n);
        chk("t6_high_rest", 32'(n), 5);
        chk("t6_pulse_first", 32'(pulso_bajada), 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6_pulse", 32'(pulso_bajada), ((k % 4) == 0) ? 1 : 0);
            chk("t6_clk", 32'(reloj_div), (((k % 4) == 2) || ((k % 4) == 3)) ? 1 : 0);
        end
        habilitar = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_parado_pulse", 32'(pulso_bajada), 0);
            chk("t6_parado_estado", 32'(estado), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
        $finish;
    end

endmodule
